// File: rtl/via_sr_link.sv
// via_sr_link: serial link to a 6522 VIA shift register.
// RX samples VIA-driven CB1/CB2 into a byte FIFO. TX generates CB1 and shifts
// bytes into the VIA MSB first. The two paths run concurrently.
module via_sr_link #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cb1_out,
    input  logic       cb2_out,
    output logic       cb1_in,
    output logic       cb2_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    input  logic       rx_overflow_clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH} tx_state_t;

    // ---------------- RX ----------------
    logic          cb1_prev;
    logic          rx_edge;
    logic [7:0]    rx_sh;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          push;
    logic [7:0]    rx_byte;

    assign rx_edge = enable && !cb1_prev && cb1_out;
    assign push    = rx_edge && (bit_cnt == 3'd7);
    assign rx_byte = {rx_sh[6:0], cb2_out};

    // Previous CB1 level; resets high so a high line at release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cb1_prev <= 1'b1;
        else        cb1_prev <= cb1_out;
    end

    // RX shifter, bit counter and idle timeout that drops a stalled partial byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sh   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (!enable) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (rx_edge) begin
            rx_sh   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
            to_cnt  <= '0;
        end else if (bit_cnt != 3'd0) begin
            if (to_cnt == TW'(RX_TIMEOUT - 1)) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, pop, wr_en;

    assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
    assign rx_valid = (cnt != '0);
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_byte;
    end

    // FIFO pointers, occupancy and sticky overflow (set wins over clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (push && full && !pop)  rx_overflow <= 1'b1;
            else if (rx_overflow_clr)  rx_overflow <= 1'b0;
        end
    end

    // ---------------- TX ----------------
    tx_state_t  state, nstate;
    logic [7:0] div_cnt;
    logic [2:0] bit_idx;
    logic [7:0] tx_sh;
    logic       div_done;

    assign div_done = (div_cnt == 8'(CLK_DIV - 1));

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= TX_IDLE;
        else        state <= nstate;
    end

    // TX next state and line outputs; enable low always returns to idle.
    always_comb begin
        nstate   = state;
        tx_ready = 1'b0;
        cb1_in   = 1'b1;
        cb2_in   = 1'b1;
        case (state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid && enable) nstate = TX_LOW;
            end
            TX_LOW: begin
                cb1_in = 1'b0;
                cb2_in = tx_sh[7];
                if (div_done) nstate = TX_HIGH;
            end
            TX_HIGH: begin
                cb2_in = tx_sh[7];
                if (div_done) nstate = (bit_idx == 3'd7) ? TX_IDLE : TX_LOW;
            end
            default: nstate = TX_IDLE;
        endcase
        if (!enable) nstate = TX_IDLE;
    end

    // TX half-period divider, byte shifter and bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_idx <= '0;
            tx_sh   <= '0;
        end else begin
            if (state == TX_IDLE || div_done || !enable) div_cnt <= '0;
            else                                          div_cnt <= div_cnt + 8'd1;
            if (state == TX_IDLE && nstate == TX_LOW) begin
                tx_sh   <= tx_data;
                bit_idx <= '0;
            end else if (state == TX_HIGH && div_done && enable) begin
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_via_sr_link.sv
// Bench for via_sr_link: RX bytes checked through a scoreboard queue,
// TX waveforms checked bit by bit against the offered byte.
module tb_via_sr_link;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       cb1_out = 1'b0;
    logic       cb2_out = 1'b0;
    logic       cb1_in, cb2_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overflow;
    logic       rx_overflow_clr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];

    via_sr_link #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .RX_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cb1_out(cb1_out), .cb2_out(cb2_out),
        .cb1_in(cb1_in), .cb2_in(cb2_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_overflow_clr(rx_overflow_clr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        cb2_out = b;
        cb1_out = 1'b0;
        step(2);
        cb1_out = 1'b1;
        step(2);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit kept);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        if (kept) rx_q.push_back(v);
    endtask

    // Pop everything the DUT holds, comparing against the scoreboard.
    task automatic drain(input string name);
        logic [7:0] exp;
        int n = 0;
        while (rx_valid && n < 16) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL %s: stray byte got %02h required none", name, rx_data);
            end else begin
                exp = rx_q.pop_front();
                if (rx_data !== exp) begin
                    errors++;
                    $display("FAIL %s: rx_data got %02h required %02h", name, rx_data, exp);
                end
            end
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
            n++;
        end
        checks++;
        if (rx_q.size() != 0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: leftover got q=%0d valid=%b required q=0 valid=0",
                     name, rx_q.size(), rx_valid);
            rx_q.delete();
        end
    endtask

    task automatic check_idle_lines(input string name);
        checks++;
        if ({cb1_in, cb2_in, tx_ready} !== 3'b111) begin
            errors++;
            $display("FAIL %s: cb1/cb2/tx_ready got %b%b%b required 111",
                     name, cb1_in, cb2_in, tx_ready);
        end
    endtask

    task automatic tx_byte(input logic [7:0] v, input string name);
        logic exp_bits[$];
        logic prev;
        int low = 0, rises = 0, n = 0;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(v[i]);
        while (!tx_ready && n < 200) begin step(1); n++; end
        tx_data  = v;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: tx_ready got %b required 0", name, tx_ready);
        end
        prev = cb1_in;
        n = 0;
        while (!tx_ready && n < 1000) begin
            if (!cb1_in) low++;
            step(1);
            n++;
            if (!prev && cb1_in) begin
                rises++;
                checks++;
                if (low != CLK_DIV) begin
                    errors++;
                    $display("FAIL %s low width: got %0d required %0d", name, low, CLK_DIV);
                end
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL %s: extra cb1 rise got %0d required 8", name, rises);
                end else if (cb2_in !== exp_bits.pop_front()) begin
                    errors++;
                    $display("FAIL %s bit %0d: cb2_in got %b required %b",
                             name, rises - 1, cb2_in, v[8 - rises]);
                end
                low = 0;
            end
            prev = cb1_in;
        end
        checks++;
        if (n != 16 * CLK_DIV || rises != 8) begin
            errors++;
            $display("FAIL %s timing: cycles got %0d rises %0d required %0d and 8",
                     name, n, rises, 16 * CLK_DIV);
        end
        check_idle_lines({name, " end"});
    endtask

    task automatic test_reset();
        step(2);
        check_idle_lines("reset held");
        checks++;
        if ({rx_valid, rx_overflow} !== 2'b00 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset held: valid/ovf/data got %b%b %02h required 00 00",
                     rx_valid, rx_overflow, rx_data);
        end
        reset  = 1'b1;
        enable = 1'b1;
        step(2);
        check_idle_lines("reset released");
        checks++;
        if ({rx_valid, rx_overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset released: valid/ovf got %b%b required 00",
                     rx_valid, rx_overflow);
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] v = 8'hE7;
        rx_q.push_back(v);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        cb2_out = v[0];
        cb1_out = 1'b0;
        step(2);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx early: rx_valid got %b required 0", rx_valid);
        end
        cb1_out = 1'b1;
        step(1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== rx_q[0]) begin
            errors++;
            $display("FAIL rx byte: valid/data got %b %02h required 1 %02h",
                     rx_valid, rx_data, rx_q[0]);
        end
        drain("rx basic");
    endtask

    task automatic test_tx_basic();
        tx_byte(8'hC3, "tx C3");
    endtask

    task automatic test_overflow();
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        send_byte(8'h55, 0);
        checks++;
        if (rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow set: got %b required 1", rx_overflow);
        end
        drain("overflow order");
        checks++;
        if (rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow sticky: got %b required 1", rx_overflow);
        end
        rx_overflow_clr = 1'b1;
        step(1);
        rx_overflow_clr = 1'b0;
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear: got %b required 0", rx_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v = 8'h66;
        logic [7:0] exp;
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 1);
        send_byte(8'hA3, 1);
        send_byte(8'hA4, 1);
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        cb2_out = v[0];
        cb1_out = 1'b0;
        step(2);
        cb1_out  = 1'b1;
        exp      = rx_q.pop_front();
        checks++;
        if (rx_data !== exp) begin
            errors++;
            $display("FAIL full push/pop head: got %02h required %02h", rx_data, exp);
        end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        rx_q.push_back(v);
        checks++;
        if (rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full push/pop: rx_overflow got %b required 0", rx_overflow);
        end
        drain("full push/pop");
    endtask

    task automatic test_timeout();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        step(1100);
        send_byte(8'h55, 1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
            errors++;
            $display("FAIL timeout byte: valid/data got %b %02h required 1 55",
                     rx_valid, rx_data);
        end
        drain("timeout");
    endtask

    task automatic start_tx_into_bit3();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(26);
        checks++;
        if (cb1_in !== 1'b0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL bit3 low: cb1/tx_ready got %b%b required 00", cb1_in, tx_ready);
        end
    endtask

    task automatic test_abort_enable();
        start_tx_into_bit3();
        enable = 1'b0;
        step(1);
        check_idle_lines("enable abort");
        enable = 1'b1;
        step(1);
        tx_byte(8'hA5, "tx A5 after enable");
        send_byte(8'h3C, 1);
        drain("rx after enable abort");
    endtask

    task automatic test_abort_reset();
        start_tx_into_bit3();
        reset = 1'b0;
        #1;
        check_idle_lines("async reset");
        step(2);
        reset = 1'b1;
        step(1);
        tx_byte(8'hA5, "tx A5 after reset");
        send_byte(8'hC9, 1);
        drain("rx after reset abort");
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_abort_enable();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/via_sr_link.md
VIA_SR_LINK -- requirements
Module: via_sr_link

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per half-period of the generated CB1 clock (range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning RX byte FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter RX_TIMEOUT, default 1024, meaning idle clk cycles after which a partial RX byte is discarded.
REQ-004 SHALL have one clock and reset; reset is asynchronous and active-low: `clk  input  1  system clock`.
REQ-005 SHALL have `reset  input  1  asynchronous, active-low reset`.
REQ-006 SHALL have `enable  input  1  link enable; low aborts TX and clears RX partial byte`.
REQ-007 SHALL have `cb1_out  input  1  VIA shift clock out (RX sample clock)`.
REQ-008 SHALL have `cb2_out  input  1  VIA serial data out`.
REQ-009 SHALL have `cb1_in  output  1  external shift clock to VIA`.
REQ-010 SHALL have `cb2_in  output  1  serial data to VIA`.
REQ-011 SHALL have `rx_data  output  8  FIFO head byte`.
REQ-012 SHALL have `rx_valid  output  1  FIFO not empty`.
REQ-013 SHALL have `rx_ready  input  1  pop head`.
REQ-014 SHALL have `rx_overflow  output  1  sticky byte-dropped flag`.
REQ-015 SHALL have `rx_overflow_clr  input  1  clear rx_overflow`.
REQ-016 SHALL have `tx_data  input  8  byte to shift into VIA`.
REQ-017 SHALL have `tx_valid  input  1  tx_data offered`.
REQ-018 SHALL have `tx_ready  output  1  TX idle, accepts byte`.

Function
REQ-019 SHALL register cb1_out each clk; an RX edge is the cycle where the previous value is 0, the current value is 1, and enable is 1.
REQ-020 SHALL, on an RX edge, shift cb2_out into the RX shifter LSB (so the first bit received ends up as the MSB) and increment a 3-bit bit counter.
REQ-021 SHALL, on the 8th RX edge, push the assembled byte into the FIFO so that rx_valid=1 and rx_data are valid on the following cycle, then reset the bit counter to 0.
REQ-022 SHALL, when pushing to a full FIFO without a simultaneous pop, drop the new byte, keep FIFO contents, and set rx_overflow.
REQ-023 SHALL perform both push and pop when a push and a pop (rx_valid && rx_ready) occur in the same cycle, including when the FIFO is full; no overflow is flagged in that case.
REQ-024 SHALL ignore rx_ready while the FIFO is empty; rx_data is show-ahead (head visible while rx_valid).
REQ-025 SHALL clear rx_overflow on rx_overflow_clr; a set and a clear in the same cycle resolve to set.
REQ-026 SHALL count clk cycles since the last RX edge while the bit counter is non-zero, and reset the bit counter to 0 when the count reaches RX_TIMEOUT.
REQ-027 SHALL implement a TX FSM with states IDLE, LOW and HIGH, where tx_ready=1 only in IDLE.
REQ-028 SHALL, in IDLE on tx_valid with enable=1, latch tx_data, clear the bit index, and enter LOW.
REQ-029 SHALL, in LOW, drive cb1_in=0 and cb2_in=shifter bit7 for CLK_DIV cycles, then enter HIGH.
REQ-030 SHALL, in HIGH, drive cb1_in=1 with cb2_in unchanged for CLK_DIV cycles, then shift the shifter left and increment the bit index; after bit index 7 it returns to IDLE, otherwise it re-enters LOW.
REQ-031 SHALL have a full TX byte take exactly 16*CLK_DIV cycles from acceptance to tx_ready=1.
REQ-032 SHALL drive cb1_in=1 and cb2_in=1 in IDLE.
REQ-033 SHALL, on enable=0, force the TX FSM to IDLE (lines to 1 on the next cycle), clear the RX bit counter and timeout counter, and retain FIFO contents.
REQ-034 SHALL have the RX and TX paths operate independently and concurrently.

Reset
REQ-035 SHALL, while reset=0, force cb1_in=1, cb2_in=1, rx_valid=0, rx_overflow=0, tx_ready=1, rx_data=0x00, the FIFO empty, the TX FSM in IDLE, and all counters at 0.
REQ-036 SHALL, on reset asserted mid-TX or mid-RX, abandon the operation immediately (asynchronously), with no partial byte pushed after release.

Verification
REQ-037 SHALL cover: reset asserted/released -> cb1_in=1, cb2_in=1, tx_ready=1, rx_valid=0, rx_overflow=0.
REQ-038 SHALL cover: 8 cb1_out rising edges with cb2_out bits 1,1,1,0,0,1,1,1 -> rx_valid=1 one cycle after the 8th edge, rx_data=0xE7; pop -> rx_valid=0.
REQ-039 SHALL cover: tx_data=0xC3 with CLK_DIV=4 -> 8 low pulses of 4 clks each, cb2_in at each cb1_in rise =1,1,0,0,0,0,1,1, and tx_ready back high 64 clks after acceptance.
REQ-040 SHALL cover: 5 bytes received with no pops (FIFO_DEPTH=4) -> first 4 bytes popped in order, 5th lost, rx_overflow=1; rx_overflow_clr -> 0.
REQ-041 SHALL cover: 3 RX bits, a gap of 1024 clks, then 8 bits of 0x55 -> single byte 0x55 received and no stray byte.
REQ-042 SHALL cover: reset or enable=0 during TX bit 3 -> cb1_in=1, cb2_in=1, tx_ready=1, and the next 0xA5 transmits correctly.
